mux8_scan_ctrl: RTL
===================

# mux8_scan_ctrl

Scan controller that sits directly upstream of the 8-to-1 mux (`HW2_mux8to1`) in the HW2 datapath. It accepts one byte over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all eight positions at a programmable rate. It samples the mux output once per bit period and emits the result as a registered serial bit stream with a per-bit strobe, so the mux plus this block together form a parallel-to-serial converter.

## Interface
- `CYCLES_PER_BIT`, default 4: clock cycles each select value is held. Legal range is 1 to 256.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `in_data`  in  8  byte to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a byte. It is high only in IDLE and is forced low while `rst_n` is low.
- `mux_in`  out  8  drives the mux `in` port.
- `mux_sel`  out  3  drives the mux `sel` port.
- `mux_out`  in  1  mux `out`, returned to this block.
- `ser_bit`  out  1  registered sample of `mux_out`.
- `ser_valid`  out  1  one-cycle strobe marking a new `ser_bit`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse after the 8th bit is sampled.

## Operation
- Mux convention, fixed: `sel = k` selects `in[7-k]`. Stepping `mux_sel` from 0 to 7 therefore sends the byte MSB first.
- FSM states:
  - IDLE: on `in_valid && in_ready` at an edge, set `mux_in <= in_data`, `mux_sel <= 0`, `cnt <= 0`, and go to SHIFT.
  - SHIFT: `cnt` increments every cycle. When `cnt == CYCLES_PER_BIT-1`:
    - `ser_bit <= mux_out` and `ser_valid <= 1`;
    - `cnt <= 0`;
    - if `mux_sel == 7`: `done <= 1` and go to IDLE;
    - otherwise `mux_sel <= mux_sel + 1`.
- `mux_in` is held constant for the whole byte. It keeps its last value in IDLE.
- `mux_sel` stays at 7 in IDLE after a byte. It is never incremented past 7 and never wraps inside a byte.
- Counter width is `max(1, $clog2(CYCLES_PER_BIT))`. With `CYCLES_PER_BIT = 1`, `cnt` stays 0 and a sample is taken every cycle.
- `in_valid` during SHIFT is ignored. No byte is queued, and the source must hold the byte until `in_ready`.
- Reset values (on any edge with `rst_n = 0`, including mid-byte):
  - state = IDLE;
  - `mux_in = 8'h00`, `mux_sel = 3'd0`, `cnt = 0`;
  - `ser_bit = 0`, `ser_valid = 0`, `done = 0`, `busy = 0`.
- A partially sent byte is discarded, and no `done` is produced for it.

## Timing
- Edge E0 is the handshake edge; N = `CYCLES_PER_BIT`.
- From E0 onward:
  - `mux_in` and `mux_sel` are valid;
  - `busy = 1`;
  - `in_ready = 0`.
- Bit k (k = 0..7) is sampled at edge E0+(k+1)·N. `ser_valid` is high for the one cycle after that edge.
- After edge E0+8N:
  - `ser_valid = 1` and `done = 1` in the same cycle;
  - `busy = 0` and `in_ready = 1`.
- The earliest next handshake is edge E0+8N+1. Throughput is one byte per 8N+1 cycles.
- The mux is combinational. `mux_out` is sampled N-1 full cycles after the select change, or in the same cycle when N = 1.

## Structure
- Package `mux8_pkg` contains:
  - `DATA_W = 8` and `SEL_W = 3`;
  - state enum `scan_state_t {IDLE, SHIFT}`.
- One sub-module, `mux8_bit_timer`. It is parameterized by `CYCLES_PER_BIT`, takes inputs `clk`, `rst_n` and `run`, and outputs `tick` (high when `cnt == N-1`). `cnt` clears when `run` is low.
- The mux itself is not instantiated here. The HW2 top level connects `mux_in`/`mux_sel`/`mux_out` to `HW2_mux8to1`.

## Test plan
- Reset then idle, N=4: after reset, all outputs are 0 and `in_ready = 1` → no `ser_valid` over 50 cycles.
- Single byte 8'hA5, N=4, real mux connected:
  - `ser_valid` pulses at E0+4, +8, …, +32;
  - `ser_bit` sequence is 1,0,1,0,0,1,0,1;
  - `done` coincides with the 8th strobe;
  - `mux_sel` reads 0..7, four cycles each.
- Back-to-back 8'hFF then 8'h00 with `in_valid` held high, N=1:
  - the second handshake lands exactly 9 cycles after the first;
  - stream is eight 1s then eight 0s.
- `in_valid` pulsed with 8'h3C during SHIFT of 8'h81 → ignored; output stream is 1,0,0,0,0,0,0,1 only.
- `rst_n` low for one edge at E0+13 during 8'hF0, N=4:
  - exactly three strobes are seen before reset (1,1,1);
  - no `done`;
  - outputs are at reset values after the edge;
  - a new byte 8'h0F then serializes correctly.
- N=256, byte 8'h01 → first strobe at E0+256, final `done` at E0+2048.

Source files
------------

// File: rtl/mux8_pkg.sv
// Shared widths and FSM state type for the mux8 scan controller.
package mux8_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } scan_state_t;
endpackage

// File: rtl/mux8_bit_timer.sv
// Bit-period counter: ticks on the last cycle of each CYCLES_PER_BIT window while run is high.
module mux8_bit_timer #(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Counter restarts at zero whenever the scan is not running, so each byte starts a fresh period.
  always_comb begin
    cnt_next = cnt_reg;
    if (!run || (cnt_reg == CNT_LAST)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = run && (cnt_reg == CNT_LAST);
endmodule

// File: rtl/mux8_scan_ctrl.sv
// Parallel-to-serial front end for an external 8:1 mux: holds a byte on the mux inputs
// and walks the select 0..7 (MSB first), sampling the mux output once per bit period.
module mux8_scan_ctrl
  import mux8_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);
  localparam logic [SEL_W-1:0] SEL_LAST = '1;

  scan_state_t       state_reg, state_next;
  logic [DATA_W-1:0] mux_in_reg, mux_in_next;
  logic [SEL_W-1:0]  mux_sel_reg, mux_sel_next;
  logic              ser_bit_reg, ser_bit_next;
  logic              ser_valid_reg, ser_valid_next;
  logic              done_reg, done_next;
  logic              tick;

  mux8_bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_reg == SHIFT),
    .tick (tick)
  );

  always_comb begin
    state_next     = state_reg;
    mux_in_next    = mux_in_reg;
    mux_sel_next   = mux_sel_reg;
    ser_bit_next   = ser_bit_reg;
    ser_valid_next = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mux_in_next  = in_data;
          mux_sel_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        // Select was set a full period ago, so the mux output has settled by now.
        if (tick) begin
          ser_bit_next   = mux_out;
          ser_valid_next = 1'b1;
          if (mux_sel_reg == SEL_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            mux_sel_next = mux_sel_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mux_in_reg    <= '0;
      mux_sel_reg   <= '0;
      ser_bit_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mux_in_reg    <= mux_in_next;
      mux_sel_reg   <= mux_sel_next;
      ser_bit_reg   <= ser_bit_next;
      ser_valid_reg <= ser_valid_next;
      done_reg      <= done_next;
    end
  end

  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign busy      = (state_reg == SHIFT);
  assign mux_in    = mux_in_reg;
  assign mux_sel   = mux_sel_reg;
  assign ser_bit   = ser_bit_reg;
  assign ser_valid = ser_valid_reg;
  assign done      = done_reg;
endmodule
